// File: rtl/flow_decoder.sv
`timescale 1ns/1ps
// flow_decoder: one-stage registered decoder for jump/call/return flow ops,
// with a return-address stack and sticky overflow/underflow flags.
// Ports: clk, rst (async, active high); in_valid/in_ready with instr, pc,
// zero_flag; flush; out_valid/out_ready with op_code, source1/2,
// destination, *_choice, jmp/cal/ret/push/pop, target_pc, stack_level,
// stack_overflow, stack_underflow.
module flow_decoder #(
    parameter int PC_WIDTH          = 5,
    parameter int OPCODE_WIDTH      = 5,
    parameter int VALUE_WIDTH       = 8,
    parameter int STACK_DEPTH       = 4,
    parameter int INSTRUCTION_WIDTH = OPCODE_WIDTH + 3*VALUE_WIDTH + 8
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [INSTRUCTION_WIDTH-1:0]       instr,
    input  logic [PC_WIDTH-1:0]                pc,
    input  logic                               zero_flag,
    input  logic                               flush,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [OPCODE_WIDTH-1:0]            op_code,
    output logic [VALUE_WIDTH-1:0]             source1,
    output logic [VALUE_WIDTH-1:0]             source2,
    output logic [VALUE_WIDTH-1:0]             destination,
    output logic [1:0]                         source1_choice,
    output logic [1:0]                         source2_choice,
    output logic [1:0]                         destination_choice,
    output logic                               jmp,
    output logic                               cal,
    output logic                               ret,
    output logic                               push,
    output logic                               pop,
    output logic [PC_WIDTH-1:0]                target_pc,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   stack_level,
    output logic                               stack_overflow,
    output logic                               stack_underflow
);

    localparam int V     = VALUE_WIDTH;
    localparam int LW    = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    localparam logic [OPCODE_WIDTH-1:0] OP_JMP     = OPCODE_WIDTH'(16);
    localparam logic [OPCODE_WIDTH-1:0] OP_IF0JUMP = OPCODE_WIDTH'(17);
    localparam logic [OPCODE_WIDTH-1:0] OP_IF1JUMP = OPCODE_WIDTH'(18);
    localparam logic [OPCODE_WIDTH-1:0] OP_CALL    = OPCODE_WIDTH'(19);
    localparam logic [OPCODE_WIDTH-1:0] OP_CAL0    = OPCODE_WIDTH'(20);
    localparam logic [OPCODE_WIDTH-1:0] OP_CAL1    = OPCODE_WIDTH'(21);
    localparam logic [OPCODE_WIDTH-1:0] OP_RET     = OPCODE_WIDTH'(22);
    localparam logic [OPCODE_WIDTH-1:0] OP_RET0    = OPCODE_WIDTH'(23);
    localparam logic [OPCODE_WIDTH-1:0] OP_RET1    = OPCODE_WIDTH'(24);

    logic [OPCODE_WIDTH-1:0] f_op;
    logic [V-1:0]            f_src1;
    logic [V-1:0]            f_src2;
    logic [V-1:0]            f_dst;
    logic [PC_WIDTH-1:0]     jump_addr;
    logic                    unused_bits;

    assign f_op        = instr[OPCODE_WIDTH+3*V+7 : 3*V+8];
    assign f_src1      = instr[3*V+7 : 2*V+8];
    assign f_src2      = instr[2*V+7 : V+8];
    assign f_dst       = instr[V+7 : 8];
    assign jump_addr   = f_src1[PC_WIDTH-1:0];
    assign unused_bits = &{1'b0, instr[7:6]};

    logic [PC_WIDTH-1:0] stack_mem [STACK_DEPTH];

    logic             stack_full;
    logic             stack_empty;
    logic [IDX_W-1:0] push_idx;
    logic [IDX_W-1:0] top_idx;

    assign stack_full  = (stack_level == LW'(STACK_DEPTH));
    assign stack_empty = (stack_level == '0);
    assign push_idx    = IDX_W'(stack_level);
    assign top_idx     = IDX_W'(stack_level - LW'(1));

    logic xfer;

    assign in_ready = !flush && (!out_valid || out_ready);
    assign xfer     = in_valid && in_ready;

    logic take_jump;
    logic take_call;
    logic take_ret;

    always_comb begin
        take_jump = 1'b0;
        take_call = 1'b0;
        take_ret  = 1'b0;
        case (f_op)
            OP_JMP:     take_jump = 1'b1;
            OP_IF0JUMP: take_jump = !zero_flag;
            OP_IF1JUMP: take_jump = zero_flag;
            OP_CALL:    take_call = 1'b1;
            OP_CAL0:    take_call = !zero_flag;
            OP_CAL1:    take_call = zero_flag;
            OP_RET:     take_ret  = 1'b1;
            OP_RET0:    take_ret  = !zero_flag;
            OP_RET1:    take_ret  = zero_flag;
            default:    ;
        endcase
    end

    // A return on an empty stack still signals ret/pop but lands on 0.
    logic [PC_WIDTH-1:0] next_target;

    always_comb begin
        next_target = '0;
        if (take_jump || take_call) begin
            next_target = jump_addr;
        end else if (take_ret && !stack_empty) begin
            next_target = stack_mem[top_idx];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid          <= 1'b0;
            op_code            <= '0;
            source1            <= '0;
            source2            <= '0;
            destination        <= '0;
            source1_choice     <= '0;
            source2_choice     <= '0;
            destination_choice <= '0;
            jmp                <= 1'b0;
            cal                <= 1'b0;
            ret                <= 1'b0;
            push               <= 1'b0;
            pop                <= 1'b0;
            target_pc          <= '0;
            stack_level        <= '0;
            stack_overflow     <= 1'b0;
            stack_underflow    <= 1'b0;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stack_mem[i] <= '0;
            end
        end else if (xfer) begin
            out_valid          <= 1'b1;
            op_code            <= f_op;
            source1            <= f_src1;
            source2            <= f_src2;
            destination        <= f_dst;
            source1_choice     <= instr[5:4];
            source2_choice     <= instr[3:2];
            destination_choice <= instr[1:0];
            jmp                <= take_jump || take_call;
            cal                <= take_call;
            ret                <= take_ret;
            push               <= take_call;
            pop                <= take_ret;
            target_pc          <= next_target;
            if (take_call) begin
                if (!stack_full) begin
                    stack_mem[push_idx] <= pc + PC_WIDTH'(1);
                    stack_level         <= stack_level + LW'(1);
                end else begin
                    stack_overflow <= 1'b1;
                end
            end
            if (take_ret) begin
                if (!stack_empty) begin
                    stack_level <= stack_level - LW'(1);
                end else begin
                    stack_underflow <= 1'b1;
                end
            end
        end else if (flush || out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_flow_decoder.sv
`timescale 1ns/1ps
// tb_flow_decoder: vector table, directed corner sequences and a randomized
// run against a queue-based reference model of the flow decoder.
module tb_flow_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [36:0] instr;
    logic [4:0]  pc;
    logic        zero_flag;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  op_code;
    logic [7:0]  source1, source2, destination;
    logic [1:0]  source1_choice, source2_choice, destination_choice;
    logic        jmp, cal, ret, push, pop;
    logic [4:0]  target_pc;
    logic [2:0]  stack_level;
    logic        stack_overflow, stack_underflow;

    flow_decoder dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .pc(pc), .zero_flag(zero_flag),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .op_code(op_code),
        .source1(source1), .source2(source2), .destination(destination),
        .source1_choice(source1_choice),
        .source2_choice(source2_choice),
        .destination_choice(destination_choice),
        .jmp(jmp), .cal(cal), .ret(ret), .push(push), .pop(pop),
        .target_pc(target_pc), .stack_level(stack_level),
        .stack_overflow(stack_overflow),
        .stack_underflow(stack_underflow)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [36:0] mk(input logic [4:0] op,
                                       input logic [7:0] s1,
                                       input logic [7:0] s2,
                                       input logic [7:0] d,
                                       input logic [5:0] ch);
        return {op, s1, s2, d, 2'b00, ch};
    endfunction

    function automatic logic [4:0] ctl();
        return {push, pop, jmp, cal, ret};
    endfunction

    function automatic logic [44:0] dut_data();
        return {op_code, source1, source2, destination, source1_choice,
                source2_choice, destination_choice, ctl(), target_pc};
    endfunction

    // Offer one instruction; caller guarantees in_ready (out_ready=1, no flush).
    task automatic send(input logic [4:0] op, input logic [7:0] s1,
                        input logic [4:0] p, input logic z);
        instr     = mk(op, s1, 8'h5A, 8'hC3, 6'h2D);
        pc        = p;
        zero_flag = z;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    typedef struct {
        logic [4:0] op;
        logic [7:0] s1;
        logic [4:0] pc;
        logic       zf;
        logic [4:0] ctl;
        logic [4:0] tgt;
        logic [2:0] lvl;
    } vec_t;

    vec_t vecs[17];

    // Reference model state
    logic        m_valid;
    logic [44:0] m_data;
    logic        m_ovf, m_unf;
    int          m_stk[$];

    task automatic model_reset();
        m_valid = 1'b0;
        m_data  = '0;
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
        m_stk.delete();
    endtask

    task automatic model_step(input logic v, input logic [36:0] ins,
                              input logic [4:0] p, input logic z,
                              input logic f, input logic ordy);
        int op, kind, cnd, tgt;
        logic taken;
        logic [4:0] c;
        if (v && !f && (!m_valid || ordy)) begin
            op    = int'(ins[36:32]);
            c     = 5'b00000;
            tgt   = 0;
            taken = 1'b0;
            kind  = 0;
            if (op >= 16 && op <= 24) begin
                kind  = (op - 16) / 3;
                cnd   = (op - 16) % 3;
                taken = (cnd == 0) || (cnd == 1 && !z) || (cnd == 2 && z);
            end
            if (taken) begin
                if (kind == 0) begin
                    c   = 5'b00100;
                    tgt = int'(ins[28:24]);
                end else if (kind == 1) begin
                    c   = 5'b10110;
                    tgt = int'(ins[28:24]);
                    if (m_stk.size() < 4) m_stk.push_back((int'(p) + 1) % 32);
                    else m_ovf = 1'b1;
                end else begin
                    c = 5'b01001;
                    if (m_stk.size() > 0) tgt = m_stk.pop_back();
                    else m_unf = 1'b1;
                end
            end
            m_valid = 1'b1;
            m_data  = {ins[36:8], ins[5:0], c, tgt[4:0]};
        end else if (f || ordy) begin
            m_valid = 1'b0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{5'h13, 8'h07, 5'h03, 1'b0, 5'b10110, 5'h07, 3'd1};
        vecs[1]  = '{5'h16, 8'h00, 5'h08, 1'b0, 5'b01001, 5'h04, 3'd0};
        vecs[2]  = '{5'h11, 8'h0A, 5'h00, 1'b1, 5'b00000, 5'h00, 3'd0};
        vecs[3]  = '{5'h11, 8'h0A, 5'h00, 1'b0, 5'b00100, 5'h0A, 3'd0};
        vecs[4]  = '{5'h12, 8'h15, 5'h01, 1'b0, 5'b00000, 5'h00, 3'd0};
        vecs[5]  = '{5'h12, 8'h15, 5'h01, 1'b1, 5'b00100, 5'h15, 3'd0};
        vecs[6]  = '{5'h14, 8'h1F, 5'h1F, 1'b0, 5'b10110, 5'h1F, 3'd1};
        vecs[7]  = '{5'h17, 8'h00, 5'h02, 1'b1, 5'b00000, 5'h00, 3'd1};
        vecs[8]  = '{5'h17, 8'h00, 5'h02, 1'b0, 5'b01001, 5'h00, 3'd0};
        vecs[9]  = '{5'h15, 8'h2C, 5'h0A, 1'b1, 5'b10110, 5'h0C, 3'd1};
        vecs[10] = '{5'h05, 8'h33, 5'h04, 1'b0, 5'b00000, 5'h00, 3'd1};
        vecs[11] = '{5'h18, 8'h00, 5'h05, 1'b1, 5'b01001, 5'h0B, 3'd0};
        vecs[12] = '{5'h18, 8'h00, 5'h05, 1'b1, 5'b01001, 5'h00, 3'd0};
        vecs[13] = '{5'h19, 8'h09, 5'h06, 1'b0, 5'b00000, 5'h00, 3'd0};
        vecs[14] = '{5'h0F, 8'h09, 5'h06, 1'b0, 5'b00000, 5'h00, 3'd0};
        vecs[15] = '{5'h10, 8'hE3, 5'h07, 1'b1, 5'b00100, 5'h03, 3'd0};
        vecs[16] = '{5'h16, 8'h00, 5'h07, 1'b1, 5'b01001, 5'h00, 3'd0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        instr     = '0;
        pc        = '0;
        zero_flag = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_ctl", ctl(), 0);
        chk("reset_target", target_pc, 0);
        chk("reset_level", stack_level, 0);
        chk("reset_flags", {stack_overflow, stack_underflow}, 0);
        chk("reset_in_ready", in_ready, 1);

        // Vector table
        for (int i = 0; i < 17; i++) begin
            send(vecs[i].op, vecs[i].s1, vecs[i].pc, vecs[i].zf);
            chk($sformatf("vec%0d_valid", i), out_valid, 1);
            chk($sformatf("vec%0d_op", i), op_code, vecs[i].op);
            chk($sformatf("vec%0d_ctl", i), ctl(), vecs[i].ctl);
            chk($sformatf("vec%0d_tgt", i), target_pc, vecs[i].tgt);
            chk($sformatf("vec%0d_lvl", i), stack_level, vecs[i].lvl);
        end
        chk("vec_underflow", stack_underflow, 1);
        chk("vec_overflow", stack_overflow, 0);

        // Overflow
        rst = 1'b1;
        #2;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            send(5'h13, 8'(8'h10 + i), 5'(i), 1'(i));
            chk($sformatf("ovf%0d_ctl", i), ctl(), 5'b10110);
            chk($sformatf("ovf%0d_tgt", i), target_pc, 5'(5'h10 + i));
            chk($sformatf("ovf%0d_lvl", i), stack_level, (i < 4) ? i + 1 : 4);
            chk($sformatf("ovf%0d_flag", i), stack_overflow, (i == 4) ? 1 : 0);
        end
        send(5'h01, 8'h00, 5'h00, 1'b0);
        chk("ovf_sticky", stack_overflow, 1);
        chk("ovf_level_hold", stack_level, 4);
        send(5'h16, 8'h00, 5'h00, 1'b0);
        chk("ovf_ret_tgt", target_pc, 5'h04);
        chk("ovf_ret_lvl", stack_level, 3);

        // Backpressure
        send(5'h10, 8'h11, 5'h00, 1'b0);
        out_ready = 1'b0;
        instr     = mk(5'h13, 8'h06, 8'h01, 8'h02, 6'h00);
        pc        = 5'h08;
        in_valid  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("bp%0d_in_ready", k), in_ready, 0);
            @(posedge clk);
            #1;
            chk($sformatf("bp%0d_valid", k), out_valid, 1);
            chk($sformatf("bp%0d_data", k), dut_data(),
                {5'h10, 8'h11, 8'h5A, 8'hC3, 6'h2D, 5'b00100, 5'h11});
            chk($sformatf("bp%0d_lvl", k), stack_level, 3);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("bp_next_ctl", ctl(), 5'b10110);
        chk("bp_next_tgt", target_pc, 5'h06);
        chk("bp_next_lvl", stack_level, 4);

        // Flush
        flush    = 1'b1;
        in_valid = 1'b1;
        #1;
        chk("flush_in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_valid", out_valid, 0);
        chk("flush_lvl", stack_level, 4);
        chk("flush_ovf", stack_overflow, 1);

        // Async reset between edges
        send(5'h10, 8'h07, 5'h00, 1'b0);
        chk("arst_pre_valid", out_valid, 1);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_data", dut_data(), 0);
        chk("arst_lvl", stack_level, 0);
        chk("arst_flags", {stack_overflow, stack_underflow}, 0);
        #1;
        rst = 1'b0;
        #1;
        chk("arst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;

        // Randomized run against the model
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            logic [4:0] rop;
            in_valid  = ($urandom_range(0, 99) < 70);
            rop       = ($urandom_range(0, 9) == 0) ? 5'($urandom)
                                                    : 5'($urandom_range(14, 26));
            instr     = mk(rop, 8'($urandom), 8'($urandom), 8'($urandom),
                           6'($urandom));
            instr[7:6] = 2'($urandom);
            pc        = 5'($urandom);
            zero_flag = 1'($urandom);
            out_ready = ($urandom_range(0, 99) < 70);
            flush     = ($urandom_range(0, 99) < 6);
            #1;
            chk("rand_in_ready", in_ready,
                !flush && (!m_valid || out_ready));
            model_step(in_valid, instr, pc, zero_flag, flush, out_ready);
            @(posedge clk);
            #1;
            chk("rand_valid", out_valid, m_valid);
            if (m_valid) chk("rand_data", dut_data(), m_data);
            chk("rand_level", stack_level, m_stk.size());
            chk("rand_flags", {stack_overflow, stack_underflow},
                {m_ovf, m_unf});
        end
        in_valid = 1'b0;
        flush    = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
